// File: rtl/as_gpio_seq_checker.sv
// as_gpio_seq_checker: compares the GPIO value on each cs_i rising edge against a
// programmable expected sequence and reports pass, mismatch or idle timeout.
module as_gpio_seq_checker #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int TMO_W  = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cs_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              prog_we_i,
    input  logic [AW-1:0]     prog_addr_i,
    input  logic [DATA_W-1:0] prog_data_i,
    input  logic [AW:0]       seq_len_i,
    input  logic [TMO_W-1:0]  timeout_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              pass_o,
    output logic              fail_o,
    output logic              fail_cause_o,
    output logic [AW-1:0]     fail_idx_o,
    output logic [DATA_W-1:0] fail_data_o,
    output logic [AW:0]       match_cnt_o
);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_PASS, S_FAIL} state_t;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    state_t            state_q, state_d;
    logic              cs_q;
    logic              ev;
    logic [AW-1:0]     idx_q, idx_d;
    logic [AW:0]       len_q, len_d;
    logic [AW:0]       len_clamped;
    logic [AW:0]       match_cnt_q, match_cnt_d;
    logic [TMO_W-1:0]  timer_q, timer_d, timer_inc;
    logic              fail_cause_q, fail_cause_d;
    logic [AW-1:0]     fail_idx_q, fail_idx_d;
    logic [DATA_W-1:0] fail_data_q, fail_data_d;
    logic              busy_q, pass_q, fail_q;
    logic              prog_en;
    logic [DATA_W-1:0] exp_mem [DEPTH];

    // A cs_i already high when armed, or held high, produces no further events.
    assign ev          = cs_i & ~cs_q;
    assign len_clamped = (seq_len_i > DEPTH_L) ? DEPTH_L : seq_len_i;
    assign timer_inc   = (&timer_q) ? timer_q : timer_q + 1'b1;
    assign prog_en     = prog_we_i && (state_q != S_ARMED) && (int'(prog_addr_i) < DEPTH);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        len_d        = len_q;
        match_cnt_d  = match_cnt_q;
        timer_d      = timer_q;
        fail_cause_d = fail_cause_q;
        fail_idx_d   = fail_idx_q;
        fail_data_d  = fail_data_q;

        if (start_i) begin
            len_d        = len_clamped;
            idx_d        = '0;
            timer_d      = '0;
            match_cnt_d  = '0;
            fail_cause_d = 1'b0;
            fail_idx_d   = '0;
            fail_data_d  = '0;
            state_d      = (len_clamped == '0) ? S_PASS : S_ARMED;
        end else if (state_q == S_ARMED) begin
            // An event in the same cycle as the timeout wins over it.
            if (ev) begin
                if (data_i == exp_mem[idx_q]) begin
                    match_cnt_d = match_cnt_q + 1'b1;
                    timer_d     = '0;
                    if ({1'b0, idx_q} == len_q - 1'b1) begin
                        state_d = S_PASS;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    state_d      = S_FAIL;
                    fail_cause_d = 1'b0;
                    fail_idx_d   = idx_q;
                    fail_data_d  = data_i;
                end
            end else begin
                timer_d = timer_inc;
                if ((timeout_i != '0) && (timer_inc == timeout_i)) begin
                    state_d      = S_FAIL;
                    fail_cause_d = 1'b1;
                    fail_idx_d   = idx_q;
                    fail_data_d  = '0;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            cs_q         <= 1'b0;
            idx_q        <= '0;
            len_q        <= '0;
            match_cnt_q  <= '0;
            timer_q      <= '0;
            fail_cause_q <= 1'b0;
            fail_idx_q   <= '0;
            fail_data_q  <= '0;
            busy_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cs_q         <= cs_i;
            idx_q        <= idx_d;
            len_q        <= len_d;
            match_cnt_q  <= match_cnt_d;
            timer_q      <= timer_d;
            fail_cause_q <= fail_cause_d;
            fail_idx_q   <= fail_idx_d;
            fail_data_q  <= fail_data_d;
            busy_q       <= (state_d == S_ARMED);
            pass_q       <= (state_d == S_PASS);
            fail_q       <= (state_d == S_FAIL);
        end
    end

    // Expected-value memory is cleared on reset so a fresh run never sees stale data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                exp_mem[i] <= '0;
            end
        end else if (prog_en) begin
            exp_mem[prog_addr_i] <= prog_data_i;
        end
    end

    assign busy_o       = busy_q;
    assign pass_o       = pass_q;
    assign fail_o       = fail_q;
    assign fail_cause_o = fail_cause_q;
    assign fail_idx_o   = fail_idx_q;
    assign fail_data_o  = fail_data_q;
    assign match_cnt_o  = match_cnt_q;

endmodule
